// File: rtl/sensor_conditioner.sv
// Front-end conditioning: 2-flop sync + debounce on four binary sensors, range-qualified temperature.
// Optional 4-sample moving average on the temperature path when TEMP_AVG_EN is defined.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ST_MAX          = 100
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       raw_fd,
    input  logic       raw_rd,
    input  logic       raw_w,
    input  logic       raw_fa,
    input  logic [6:0] raw_st,
    input  logic       st_valid,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [6:0] ST,
    output logic       st_err,
    output logic       evt_change
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] ST_RESET = 7'd60;
    localparam logic [6:0] ST_LIMIT = 7'(ST_MAX);

    logic [3:0]      raw;
    logic [3:0]      s1;
    logic [3:0]      s2;
    logic [3:0]      o;
    logic [3:0]      o_next;
    logic [3:0][7:0] cnt;
    logic [3:0][7:0] cnt_next;
    logic [6:0]      st_next;
    logic            accept;
    logic            reject;

    assign raw = {raw_fd, raw_rd, raw_w, raw_fa};
    assign {SFD, SRD, SW, SFA} = o;

    // Any return of s2 to the current output restarts the count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            o_next[i]   = o[i];
            cnt_next[i] = 8'd0;
            if (s2[i] != o[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    o_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 8'd1;
                end
            end
        end
    end

    assign accept = st_valid && (raw_st <= ST_LIMIT);
    assign reject = st_valid && (raw_st > ST_LIMIT);

`ifdef TEMP_AVG_EN
    logic [6:0] w0;
    logic [6:0] w1;
    logic [6:0] w2;
    logic [6:0] w3;
    logic [8:0] sum;

    // Average uses the pre-shift entries together with the incoming sample.
    assign sum     = 9'(raw_st) + 9'(w0) + 9'(w1) + 9'(w2);
    assign st_next = accept ? sum[8:2] : ST;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            w0 <= ST_RESET;
            w1 <= ST_RESET;
            w2 <= ST_RESET;
            w3 <= ST_RESET;
        end else if (accept) begin
            w0 <= raw_st;
            w1 <= w0;
            w2 <= w1;
            w3 <= w2;
        end
    end
`else
    assign st_next = accept ? raw_st : ST;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1         <= '0;
            s2         <= '0;
            o          <= '0;
            cnt        <= '0;
            ST         <= ST_RESET;
            st_err     <= 1'b0;
            evt_change <= 1'b0;
        end else begin
            s1         <= raw;
            s2         <= s1;
            o          <= o_next;
            cnt        <= cnt_next;
            ST         <= st_next;
            st_err     <= reject;
            evt_change <= |({o_next, st_next} ^ {o, ST});
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: per-edge expectations go through a scoreboard queue.
module tb_sensor_conditioner;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       raw_fd, raw_rd, raw_w, raw_fa;
    logic [6:0] raw_st;
    logic       st_valid;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       st_err;
    logic       evt_change;

    int errors = 0;
    int checks = 0;

`ifdef TEMP_AVG_EN
    bit avg = 1'b1;
`else
    bit avg = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] o;
        logic [6:0] st;
        logic       err;
        logic       evt;
    } exp_t;

    exp_t sb[$];

    sensor_conditioner #(.DEBOUNCE_CYCLES(4), .ST_MAX(100)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .raw_fd     (raw_fd),
        .raw_rd     (raw_rd),
        .raw_w      (raw_w),
        .raw_fa     (raw_fa),
        .raw_st     (raw_st),
        .st_valid   (st_valid),
        .SFD        (SFD),
        .SRD        (SRD),
        .SW         (SW),
        .SFA        (SFA),
        .ST         (ST),
        .st_err     (st_err),
        .evt_change (evt_change)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input string field, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got=%0d expected=%0d", tag, field, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic step(input string tag, input logic [3:0] eo, input logic [6:0] est,
                        input logic eerr, input logic eevt);
        exp_t e;
        exp_t g;
        e.tag = tag;
        e.o   = eo;
        e.st  = est;
        e.err = eerr;
        e.evt = eevt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        g = sb.pop_front();
        check(g.tag, "bin", {4'b0, SFD, SRD, SW, SFA}, {4'b0, g.o});
        check(g.tag, "ST", {1'b0, ST}, {1'b0, g.st});
        check(g.tag, "st_err", {7'b0, st_err}, {7'b0, g.err});
        check(g.tag, "evt", {7'b0, evt_change}, {7'b0, g.evt});
    endtask

    initial begin
        Rst = 1'b1;
        {raw_fd, raw_rd, raw_w, raw_fa} = 4'b1111;
        raw_st = 7'd0;
        st_valid = 1'b0;
        @(negedge Clk);

        step("rst0", 4'h0, 7'd60, 1'b0, 1'b0);
        step("rst1", 4'h0, 7'd60, 1'b0, 1'b0);
        Rst = 1'b0;
        {raw_fd, raw_rd, raw_w, raw_fa} = 4'b0000;
        step("idle0", 4'h0, 7'd60, 1'b0, 1'b0);
        step("idle1", 4'h0, 7'd60, 1'b0, 1'b0);

        // Debounce latency on the front door, both directions.
        raw_fd = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("fd_up_e%0d", i), 4'h0, 7'd60, 1'b0, 1'b0);
        step("fd_up_e6", 4'h8, 7'd60, 1'b0, 1'b1);
        step("fd_up_e7", 4'h8, 7'd60, 1'b0, 1'b0);
        raw_fd = 1'b0;
        for (int i = 1; i <= 5; i++) step($sformatf("fd_dn_e%0d", i), 4'h8, 7'd60, 1'b0, 1'b0);
        step("fd_dn_e6", 4'h0, 7'd60, 1'b0, 1'b1);
        step("fd_dn_e7", 4'h0, 7'd60, 1'b0, 1'b0);

        // A 3-cycle glitch is swallowed.
        raw_rd = 1'b1;
        for (int i = 1; i <= 3; i++) step($sformatf("rd3_e%0d", i), 4'h0, 7'd60, 1'b0, 1'b0);
        raw_rd = 1'b0;
        for (int i = 4; i <= 10; i++) step($sformatf("rd3_e%0d", i), 4'h0, 7'd60, 1'b0, 1'b0);

        // A 5-cycle pulse passes through as a 5-cycle output pulse.
        raw_rd = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("rd5_e%0d", i), 4'h0, 7'd60, 1'b0, 1'b0);
        raw_rd = 1'b0;
        step("rd5_e6", 4'h4, 7'd60, 1'b0, 1'b1);
        for (int i = 7; i <= 10; i++) step($sformatf("rd5_e%0d", i), 4'h4, 7'd60, 1'b0, 1'b0);
        step("rd5_e11", 4'h0, 7'd60, 1'b0, 1'b1);
        step("rd5_e12", 4'h0, 7'd60, 1'b0, 1'b0);

        // Back-to-back accepts of 40 starting from the reset window.
        st_valid = 1'b1;
        raw_st = 7'd40;
        step("acc1", 4'h0, avg ? 7'd55 : 7'd40, 1'b0, 1'b1);
        step("acc2", 4'h0, avg ? 7'd50 : 7'd40, 1'b0, avg);
        step("acc3", 4'h0, avg ? 7'd45 : 7'd40, 1'b0, avg);
        step("acc4", 4'h0, 7'd40, 1'b0, avg);

        // Range boundaries: 110 rejected, 100 accepted, invalid strobe ignored.
        raw_st = 7'd110;
        step("rej110", 4'h0, 7'd40, 1'b1, 1'b0);
        st_valid = 1'b0;
        step("rej_end", 4'h0, 7'd40, 1'b0, 1'b0);
        st_valid = 1'b1;
        raw_st = 7'd100;
        step("acc100", 4'h0, avg ? 7'd55 : 7'd100, 1'b0, 1'b1);
        st_valid = 1'b0;
        raw_st = 7'd0;
        step("ign0_a", 4'h0, avg ? 7'd55 : 7'd100, 1'b0, 1'b0);
        step("ign0_b", 4'h0, avg ? 7'd55 : 7'd100, 1'b0, 1'b0);

        // Reset in the middle of a fire-alarm debounce and a window fill.
        raw_fa = 1'b1;
        step("fa_e1", 4'h0, avg ? 7'd55 : 7'd100, 1'b0, 1'b0);
        step("fa_e2", 4'h0, avg ? 7'd55 : 7'd100, 1'b0, 1'b0);
        st_valid = 1'b1;
        raw_st = 7'd20;
        step("fa_e3", 4'h0, avg ? 7'd50 : 7'd20, 1'b0, 1'b1);
        step("fa_e4", 4'h0, avg ? 7'd45 : 7'd20, 1'b0, avg);
        st_valid = 1'b0;
        Rst = 1'b1;
        step("mid_rst", 4'h0, 7'd60, 1'b0, 1'b0);
        Rst = 1'b0;
        for (int i = 1; i <= 5; i++) step($sformatf("fa_re_e%0d", i), 4'h0, 7'd60, 1'b0, 1'b0);
        step("fa_re_e6", 4'h1, 7'd60, 1'b0, 1'b1);
        step("fa_re_e7", 4'h1, 7'd60, 1'b0, 1'b0);

        // Window must have been restored to 60 by the reset.
        st_valid = 1'b1;
        raw_st = 7'd40;
        step("post_rst_acc", 4'h1, avg ? 7'd55 : 7'd40, 1'b0, 1'b1);
        st_valid = 1'b0;
        step("post_rst_idle", 4'h1, avg ? 7'd55 : 7'd40, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
